// File: rtl/fpu_mult_arbiter.sv
// Round-robin arbiter sharing one multiplier between NUM_REQ requesters.
// One operation in flight: grant, issue, wait for done or timeout, respond.
module fpu_mult_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 63
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_result,
  output logic                          resp_error,
  output logic                          fpu_start,
  output logic [DATA_WIDTH-1:0]         fpu_a,
  output logic [DATA_WIDTH-1:0]         fpu_b,
  input  logic                          fpu_busy,
  input  logic                          fpu_done,
  input  logic [DATA_WIDTH-1:0]         fpu_result,
  output logic                          arb_busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state, state_d;
  logic [IDX_W-1:0]       ptr, ptr_d;
  logic [IDX_W-1:0]       gidx, gidx_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [NUM_REQ-1:0]     req_ready_d, resp_valid_d;
  logic [DATA_WIDTH-1:0]  resp_result_d, fpu_a_d, fpu_b_d;
  logic                   resp_error_d, fpu_start_d, arb_busy_d;

  logic                   found_c;
  logic [IDX_W-1:0]       grant_c;
  logic [DATA_WIDTH-1:0]  sel_a_c, sel_b_c;

  // Rotating priority scan starting at ptr, plus operand mux for the winner
  always_comb begin
    int unsigned cand;
    cand    = 0;
    found_c = 1'b0;
    grant_c = '0;
    sel_a_c = '0;
    sel_b_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (!found_c && req_valid[IDX_W'(cand)]) begin
        found_c = 1'b1;
        grant_c = IDX_W'(cand);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_c == IDX_W'(k)) begin
        sel_a_c = req_a[k*DATA_WIDTH +: DATA_WIDTH];
        sel_b_c = req_b[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and next-output logic; all outputs are registered below
  always_comb begin
    state_d       = state;
    ptr_d         = ptr;
    gidx_d        = gidx;
    cnt_d         = cnt;
    fpu_a_d       = fpu_a;
    fpu_b_d       = fpu_b;
    resp_result_d = resp_result;
    resp_error_d  = resp_error;
    req_ready_d   = '0;
    resp_valid_d  = '0;
    fpu_start_d   = 1'b0;

    case (state)
      IDLE: begin
        if (found_c) begin
          fpu_a_d     = sel_a_c;
          fpu_b_d     = sel_b_c;
          gidx_d      = grant_c;
          req_ready_d = NUM_REQ'(1) << grant_c;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (!fpu_busy) begin
          fpu_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt + CNT_W'(1);
        // A done arriving on the timeout cycle still counts as success
        if (fpu_done) begin
          resp_result_d = fpu_result;
          resp_error_d  = 1'b0;
          resp_valid_d  = NUM_REQ'(1) << gidx;
          state_d       = RESP;
        end else if (cnt_d == CNT_W'(TIMEOUT)) begin
          resp_result_d = '0;
          resp_error_d  = 1'b1;
          resp_valid_d  = NUM_REQ'(1) << gidx;
          state_d       = RESP;
        end
      end
      RESP: begin
        ptr_d   = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    arb_busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      gidx        <= '0;
      cnt         <= '0;
      req_ready   <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
      resp_error  <= 1'b0;
      fpu_start   <= 1'b0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      arb_busy    <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      gidx        <= gidx_d;
      cnt         <= cnt_d;
      req_ready   <= req_ready_d;
      resp_valid  <= resp_valid_d;
      resp_result <= resp_result_d;
      resp_error  <= resp_error_d;
      fpu_start   <= fpu_start_d;
      fpu_a       <= fpu_a_d;
      fpu_b       <= fpu_b_d;
      arb_busy    <= arb_busy_d;
    end
  end

endmodule
